pipe_skid_reg: RTL and testbench
================================

// Module: pipe_skid_reg
// PURPOSE
//   Parametrised pipeline register with valid/ready handshake and a one-entry skid buffer.
//   Successor to the plain enable register, for the pipelined MIPS datapath.
//   Sits between stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Also supports backpressure (stall), synchronous flush (branch/jump squash),
//   full throughput and registered ready, so no combinational ready path crosses stages.
// PARAMETERS
//   WIDTH      32   payload width in bits
//   RESET_DATA 0    value of out_data after reset/flush (WIDTH bits)
//   COUNT_W    32   width of the statistics counters (used only with PIPE_STATS_EN)
// PORTS
//   clk        in   1        clock, rising edge
//   clr        in   1        reset, asynchronous, active-high
//   flush      in   1        sync squash of all held entries
//   in_valid   in   1        upstream has data
//   in_ready   out  1        stage can accept (registered)
//   in_data    in   WIDTH    upstream payload
//   out_valid  out  1        out_data valid
//   out_ready  in   1        downstream accepts
//   out_data   out  WIDTH    payload to next stage (registered)
//   stall_cnt  out  COUNT_W  cycles with out_valid & !out_ready
//   xfer_cnt   out  COUNT_W  completed output transfers
// BEHAVIOUR
//   - Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Reset (clr=1, async): state EMPTY, out_valid=0, in_ready=1, out_data=RESET_DATA,
//     skid=RESET_DATA, counters=0. clr mid-transfer discards all entries.
//   - States:
//       EMPTY: main invalid, skid invalid.
//       BUSY:  main valid, skid invalid.
//       FULL:  main valid, skid valid.
//   - EMPTY:
//       in_fire -> BUSY, main<=in_data.
//   - BUSY:
//       in_fire & out_fire   -> BUSY, main<=in_data.
//       in_fire & !out_fire  -> FULL, skid<=in_data.
//       !in_fire & out_fire  -> EMPTY.
//   - FULL: in_ready=0.
//       out_fire -> BUSY, main<=skid.
//   - in_ready = (next state != FULL), registered; it is 0 only in FULL.
//   - Latency: data accepted at edge N appears on out_data/out_valid after edge N.
//     Throughput is 1 transfer/cycle when out_ready=1.
//   - Hold rule: while out_valid & !out_ready, out_data/out_valid stay stable.
//     No data is ever dropped or reordered (FIFO order main then skid).
//   - flush=1 at an edge:
//       * next state EMPTY; out_valid=0; in_ready=1;
//       * out_data=RESET_DATA.
//       * An in_fire on the same cycle is consumed and discarded (flush wins).
//       * An out_fire on the same cycle completes normally downstream.
//   - clr has priority over flush; flush has priority over all transfers.
// CONFIGURATION
//   PIPE_STATS_EN defined:
//     - stall_cnt increments each cycle with out_valid & !out_ready.
//     - xfer_cnt increments on each out_fire.
//     - Both counters wrap modulo 2^COUNT_W, cleared by clr only (not by flush).
//   PIPE_STATS_EN undefined:
//     - stall_cnt and xfer_cnt are tied to 0; no counter logic is synthesised.
//     - Ports remain present so the top level is unchanged.
// STRUCTURE
//   - Package pipe_pkg: state encoding localparams ST_EMPTY=2'd0, ST_BUSY=2'd1,
//     ST_FULL=2'd2; shared default COUNT_W.
//   - Sub-module pipe_stats_ctr (COUNT_W, inc, clk, clr -> cnt):
//     instantiated twice under PIPE_STATS_EN.
//   - Control FSM and the main/skid data registers stay in this module.
// TESTING
//   1. clr pulse, then idle
//      -> out_valid=0, in_ready=1, out_data=RESET_DATA, stall_cnt=xfer_cnt=0.
//   2. Stream 0x1..0x8 on consecutive cycles, out_ready=1
//      -> out_data 0x1..0x8 one per cycle, 1-cycle latency, xfer_cnt=8.
//   3. Send A=0xA, B=0xB, C=0xC with out_ready=0 for 3 cycles
//      -> in_ready=0 after B; out_data=0xA held; C held upstream.
//      Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order; stall_cnt=3.
//   4. In FULL (0xA, 0xB), assert flush with in_valid=0 then in_valid=1 data 0xD
//      -> next cycle EMPTY, out_valid=0, in_ready=1; 0xD not output.
//   5. Assert clr asynchronously mid-cycle while FULL
//      -> out_valid falls immediately without a clock edge.
//      After release, stream 0x5 -> 0x5 out next cycle.
//   6. Build without PIPE_STATS_EN and rerun scenario 3
//      -> identical data behaviour; stall_cnt=xfer_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline register: FSM encoding and
// the default statistics counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned PIPE_COUNT_W = 32;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for one pipeline stage boundary: the upstream
// (in_*) and downstream (out_*) sides of a pipe_skid_reg.
interface pipe_skid_reg_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: produces upstream data, consumes downstream data
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Register side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/pipe_stats_ctr.sv
// Free-running event counter for pipeline statistics; wraps modulo 2^COUNT_W
// and is cleared only by the asynchronous reset.
module pipe_stats_ctr #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               inc,
  output logic [COUNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register with valid/ready handshake, one-entry skid buffer, sync flush
// and registered in_ready. Optional stall/transfer counters under PIPE_STATS_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  parameter int unsigned      COUNT_W    = PIPE_COUNT_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               flush,
  pipe_skid_reg_if.slave     bus,
  output logic [COUNT_W-1:0] stall_cnt,
  output logic [COUNT_W-1:0] xfer_cnt
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_p0, main_d;
  logic [WIDTH-1:0] skid_p0, skid_d;
  logic             in_ready_q;
  logic             in_fire, out_fire;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_p0;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_p0;
    skid_d  = skid_p0;
    if (flush) begin
      // Squash wins over any transfer; an accepted input is silently discarded
      state_d = ST_EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_BUSY;
            main_d  = bus.in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            state_d = ST_FULL;
            skid_d  = bus.in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d = ST_BUSY;
            main_d  = skid_p0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stage p0: state, ready and payload registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_p0    <= RESET_DATA;
      skid_p0    <= RESET_DATA;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      main_p0    <= main_d;
      skid_p0    <= skid_d;
    end
  end

`ifdef PIPE_STATS_EN
  logic stall_ev;
  assign stall_ev = bus.out_valid & ~bus.out_ready;

  pipe_stats_ctr #(.COUNT_W(COUNT_W)) u_stall_ctr (
    .clk (clk),
    .clr (clr),
    .inc (stall_ev),
    .cnt (stall_cnt)
  );

  pipe_stats_ctr #(.COUNT_W(COUNT_W)) u_xfer_ctr (
    .clk (clk),
    .clr (clr),
    .inc (out_fire),
    .cnt (xfer_cnt)
  );
`else
  assign stall_cnt = '0;
  assign xfer_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, backpressure with skid,
// flush and asynchronous clear; counter expectations follow PIPE_STATS_EN.
module tb_pipe_skid_reg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned COUNT_W = 16;
  localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;
`ifdef PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               clr;
  logic               flush;
  logic [COUNT_W-1:0] stall_cnt;
  logic [COUNT_W-1:0] xfer_cnt;

  int vecs = 0;
  int errs = 0;

  pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

  pipe_skid_reg #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RST_VAL),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cexp(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    clr           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // 1: reset state, then idle
    #3;
    chk("rst_ovalid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_iready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_odata", bus.out_data, RST_VAL);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_xfer", {16'd0, xfer_cnt}, 32'd0);
    #5 clr = 1'b0;
    tick();
    chk("idle_ovalid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_odata", bus.out_data, RST_VAL);

    // 2: stream 1..8 at full rate
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'(i);
      tick();
      chk("strm_ovalid", {31'd0, bus.out_valid}, 32'd1);
      chk("strm_odata", bus.out_data, 32'(i));
      chk("strm_iready", {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("strm_drain", {31'd0, bus.out_valid}, 32'd0);
    chk("strm_xfer", {16'd0, xfer_cnt}, cexp(8));
    chk("strm_stall", {16'd0, stall_cnt}, cexp(0));

    // 3: backpressure fills the skid entry, then drains in order
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA;
    tick();
    chk("bp_a_odata", bus.out_data, 32'hA);
    chk("bp_a_iready", {31'd0, bus.in_ready}, 32'd1);
    bus.in_data = 32'hB;
    tick();
    chk("bp_b_odata", bus.out_data, 32'hA);
    chk("bp_b_iready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_data = 32'hC;
    tick();
    chk("bp_c1_odata", bus.out_data, 32'hA);
    chk("bp_c1_ovalid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    chk("bp_c2_odata", bus.out_data, 32'hA);
    chk("bp_c2_iready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_stall", {16'd0, stall_cnt}, cexp(3));
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out_b", bus.out_data, 32'hB);
    chk("bp_iready_back", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_out_c", bus.out_data, 32'hC);
    chk("bp_out_c_vld", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_xfer", {16'd0, xfer_cnt}, cexp(11));
    chk("bp_stall_end", {16'd0, stall_cnt}, cexp(3));

    // 4: flush while FULL, then flush against an incoming beat
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hA;
    tick();
    bus.in_data = 32'hB;
    tick();
    chk("fl_full", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b0;
    flush        = 1'b1;
    tick();
    chk("fl_ovalid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_iready", {31'd0, bus.in_ready}, 32'd1);
    chk("fl_odata", bus.out_data, RST_VAL);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hD;
    tick();
    chk("fl_d_ovalid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_d_odata", bus.out_data, RST_VAL);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("fl_after", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_stall", {16'd0, stall_cnt}, cexp(5));

    // 5: asynchronous clear mid-cycle while FULL
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h1;
    tick();
    bus.in_data = 32'h2;
    tick();
    bus.in_valid = 1'b0;
    chk("ac_full", {31'd0, bus.in_ready}, 32'd0);
    chk("ac_xfer_pre", {16'd0, xfer_cnt}, cexp(11));
    #2 clr = 1'b1;
    #1;
    chk("ac_ovalid", {31'd0, bus.out_valid}, 32'd0);
    chk("ac_iready", {31'd0, bus.in_ready}, 32'd1);
    chk("ac_odata", bus.out_data, RST_VAL);
    chk("ac_stall", {16'd0, stall_cnt}, 32'd0);
    chk("ac_xfer", {16'd0, xfer_cnt}, 32'd0);
    clr           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5;
    tick();
    chk("ac_out5", bus.out_data, 32'h5);
    chk("ac_out5_vld", {31'd0, bus.out_valid}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("ac_drain", {31'd0, bus.out_valid}, 32'd0);
    chk("ac_xfer_end", {16'd0, xfer_cnt}, cexp(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
